// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST score/argmax stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mnist_pkg;

    localparam int SUM_W        = 20;
    localparam int PIX_PER_WORD = 16;
    localparam int N_PIXELS     = 784;
    localparam int N_CLASSES    = 10;

    // One mac word covers PIX_PER_WORD pixels, so a neuron needs this many partials.
    localparam int CHUNKS = N_PIXELS / PIX_PER_WORD;

    // Class / neuron index, wide enough for up to 16 classes.
    typedef logic [3:0] class_idx_t;

endpackage

// File: rtl/mnist_score_argmax_if.sv
// Bundle of the partial-sum input and score/digit outputs of the argmax stage.
// Latency: n/a (wires only).
// Backpressure: none; the stage accepts a sum every cycle.
interface mnist_score_argmax_if #(
    parameter int SUM_W = mnist_pkg::SUM_W,
    parameter int ACC_W = 32
);
    import mnist_pkg::*;

    logic                    sum_valid;
    logic signed [SUM_W-1:0] sum_in;
    logic                    score_valid;
    logic signed [ACC_W-1:0] score;
    class_idx_t              score_idx;
    logic                    digit_valid;
    class_idx_t              digit;
    logic                    busy;

    // Producer side: drives partial sums, observes results.
    modport master (
        output sum_valid, sum_in,
        input  score_valid, score, score_idx, digit_valid, digit, busy
    );

    // Stage side: consumes partial sums, drives results.
    modport slave (
        input  sum_valid, sum_in,
        output score_valid, score, score_idx, digit_valid, digit, busy
    );

endinterface

// File: rtl/argmax_tracker.sv
// Running argmax over one image's neuron scores; emits the winning class index.
// Latency: digit_valid one cycle after the final neuron's score_valid.
// Backpressure: none; accepts a score every cycle.
module argmax_tracker
    import mnist_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int NEURONS = mnist_pkg::N_CLASSES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    score_valid,
    input  logic signed [ACC_W-1:0] score,
    input  class_idx_t              score_idx,
    output logic                    digit_valid,
    output class_idx_t              digit
);

    logic                    have_best;
    logic signed [ACC_W-1:0] best_score;
    class_idx_t              best_idx;
    logic signed [ACC_W-1:0] cand_score;
    class_idx_t              cand_idx;
    logic                    last_neuron;

    assign last_neuron = (score_idx == 4'(NEURONS - 1));

    // Winner including the incoming score; strict compare keeps the lower index on ties.
    always_comb begin
        cand_score = best_score;
        cand_idx   = best_idx;
        if (!have_best || (score > best_score)) begin
            cand_score = score;
            cand_idx   = score_idx;
        end
    end

    // Best-so-far state; cleared at the image boundary so the next image starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_best   <= 1'b0;
            best_score  <= '0;
            best_idx    <= '0;
            digit_valid <= 1'b0;
            digit       <= '0;
        end else begin
            digit_valid <= 1'b0;
            if (score_valid) begin
                if (last_neuron) begin
                    digit       <= cand_idx;
                    digit_valid <= 1'b1;
                    have_best   <= 1'b0;
                    best_score  <= '0;
                    best_idx    <= '0;
                end else begin
                    have_best   <= 1'b1;
                    best_score  <= cand_score;
                    best_idx    <= cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/mnist_score_argmax.sv
// Accumulates CHUNKS mac partials per neuron, then argmaxes NEURONS scores into a digit.
// Latency: score_valid 1 cycle, digit_valid 2 cycles after the last partial. MNIST_RELU_EN clamps negative scores to 0.
// Backpressure: none; sum_valid may be high every cycle, idle cycles hold state.
module mnist_score_argmax #(
    parameter int SUM_W   = mnist_pkg::SUM_W,
    parameter int ACC_W   = 32,
    parameter int CHUNKS  = mnist_pkg::CHUNKS,
    parameter int NEURONS = mnist_pkg::N_CLASSES
) (
    input  logic             clk,
    input  logic             rst,
    mnist_score_argmax_if.slave bus
);
    import mnist_pkg::*;

    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [CW-1:0]           chunk_cnt;
    class_idx_t              neuron_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] total;
    logic signed [ACC_W-1:0] final_score;
    logic                    last_chunk;
    logic                    score_valid_r;
    logic signed [ACC_W-1:0] score_r;
    class_idx_t              score_idx_r;
    logic                    digit_valid_w;
    class_idx_t              digit_w;

    assign sum_ext    = ACC_W'(bus.sum_in);
    assign total      = acc + sum_ext;
    assign last_chunk = (chunk_cnt == CW'(CHUNKS - 1));

    // Completed neuron score, optionally clamped so both output and compare see the same value.
    always_comb begin
        final_score = total;
`ifdef MNIST_RELU_EN
        if (total[ACC_W-1]) begin
            final_score = '0;
        end
`endif
    end

    // Accumulator and chunk/neuron counters; the last chunk publishes the score and restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_cnt     <= '0;
            neuron_cnt    <= '0;
            acc           <= '0;
            score_valid_r <= 1'b0;
            score_r       <= '0;
            score_idx_r   <= '0;
        end else begin
            score_valid_r <= 1'b0;
            if (bus.sum_valid) begin
                if (last_chunk) begin
                    score_r       <= final_score;
                    score_idx_r   <= neuron_cnt;
                    score_valid_r <= 1'b1;
                    acc           <= '0;
                    chunk_cnt     <= '0;
                    neuron_cnt    <= (neuron_cnt == 4'(NEURONS - 1)) ? '0 : neuron_cnt + 4'd1;
                end else begin
                    acc           <= total;
                    chunk_cnt     <= chunk_cnt + 1'b1;
                end
            end
        end
    end

    argmax_tracker #(
        .ACC_W   (ACC_W),
        .NEURONS (NEURONS)
    ) u_argmax (
        .clk         (clk),
        .rst         (rst),
        .score_valid (score_valid_r),
        .score       (score_r),
        .score_idx   (score_idx_r),
        .digit_valid (digit_valid_w),
        .digit       (digit_w)
    );

    assign bus.score_valid = score_valid_r;
    assign bus.score       = score_r;
    assign bus.score_idx   = score_idx_r;
    assign bus.digit_valid = digit_valid_w;
    assign bus.digit       = digit_w;
    assign bus.busy        = (chunk_cnt != '0) || (neuron_cnt != '0);

endmodule
